// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the byte-lane mask helper used by the alignment datapath.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam int MAX_BYTES = 8;

  // Mask spanning two bus words: low half is beat 0, high half is beat 1.
  function automatic logic [2*MAX_BYTES-1:0] lane_mask(input logic [1:0] size,
                                                       input logic [2:0] off);
    logic [2*MAX_BYTES-1:0] base;
    base = (16'd1 << (4'd1 << size)) - 16'd1;
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: shifts store data/masks into bus lanes
// across up to two beats and assembles/extends load data from two beats.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             uext,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  beat0,
  input  logic [XLEN-1:0]  beat1,
  output logic [BYTES-1:0] wmask0,
  output logic [BYTES-1:0] wmask1,
  output logic [XLEN-1:0]  wdata0,
  output logic [XLEN-1:0]  wdata1,
  output logic [XLEN-1:0]  rdata
);

  // Shift the access to the top, then back down, so the fill comes from the
  // access's own MSB (sign) or zero; full-width accesses pass unchanged.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] r,
                                             input logic [1:0]      sz,
                                             input logic            u);
    logic [7:0]             sh;
    logic signed [XLEN-1:0] left;
    sh   = ((8 << sz) >= XLEN) ? 8'd0 : 8'(XLEN - (8 << sz));
    left = r << sh;
    if (u) return $unsigned(left) >> sh;
    return $unsigned(left >>> sh);
  endfunction

  logic [2*BYTES-1:0] mask_wide;
  logic [2*XLEN-1:0]  wdata_wide;
  logic [XLEN-1:0]    raw;

  always_comb begin
    mask_wide  = (2*BYTES)'(lane_mask(size, 3'(off)));
    wmask0     = mask_wide[BYTES-1:0];
    wmask1     = mask_wide[2*BYTES-1:BYTES];
    wdata_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    wdata0     = wdata_wide[XLEN-1:0];
    wdata1     = wdata_wide[2*XLEN-1:XLEN];
    raw        = XLEN'({beat1, beat0} >> {off, 3'b000});
    rdata      = extend(raw, size, uext);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one core request -> up to two bus beats -> one response.
// Define LSU_MISALIGNED_EN to allow misaligned accesses (split when crossing).
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_uext,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_except,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN/8-1:0]   mem_wmask,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

`ifdef LSU_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic            except_q, except_d;
  logic            we_q, we_d;
  logic            uext_q, uext_d;
  logic [1:0]      size_q, size_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] beat0_q, beat0_d;
  logic [XLEN-1:0] beat1_q, beat1_d;

  logic             accept;
  logic             misaligned;
  logic             illegal;
  logic             crosses;
  logic [3:0]       nmask;
  logic [4:0]       span;
  logic [OFF_W-1:0] off;
  logic [XLEN-1:0]  base;

  logic [BYTES-1:0] wmask0, wmask1;
  logic [XLEN-1:0]  wdata0, wdata1;
  logic [XLEN-1:0]  ext_rdata;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    nmask      = (4'd1 << req_size) - 4'd1;
    misaligned = |({1'b0, req_addr[2:0]} & nmask);
    illegal    = ((XLEN == 32) && (req_size == SIZE_D)) || (misaligned && !MIS_EN);
  end

  assign off     = addr_q[OFF_W-1:0];
  assign base    = addr_q & ~XLEN'(BYTES - 1);
  assign span    = 5'(off) + (5'd1 << size_q);
  assign crosses = span > 5'(BYTES);

  lsu_align #(.XLEN(XLEN)) u_align (
    .off    (off),
    .size   (size_q),
    .uext   (uext_q),
    .wdata  (wdata_q),
    .beat0  (beat0_q),
    .beat1  (beat1_q),
    .wmask0 (wmask0),
    .wmask1 (wmask1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rdata  (ext_rdata)
  );

  always_comb begin
    state_d  = state_q;
    except_d = except_q;
    we_d     = we_q;
    uext_d   = uext_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beat0_d  = beat0_q;
    beat1_d  = beat1_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = req_we;
          uext_d   = req_uext;
          size_d   = req_size;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          beat0_d  = '0;
          beat1_d  = '0;
          except_d = illegal;
          state_d  = illegal ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          beat0_d = mem_rdata;
          state_d = crosses ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          beat1_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- control registers (reset) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      except_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      except_q <= except_d;
    end
  end

  // ---- request and read-data registers ----
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    uext_q  <= uext_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    beat0_q <= beat0_d;
    beat1_q <= beat1_d;
  end

  // Bus and response outputs are decoded from registered state only, so they
  // stay stable across backpressure and read as zero outside their phases.
  always_comb begin
    mem_valid   = (state_q == BEAT0) || (state_q == BEAT1);
    mem_we      = mem_valid && we_q;
    mem_addr    = '0;
    mem_wmask   = '0;
    mem_wdata   = '0;
    if (state_q == BEAT0) mem_addr = base;
    if (state_q == BEAT1) mem_addr = base + XLEN'(BYTES);
    if (mem_we) begin
      mem_wmask = (state_q == BEAT1) ? wmask1 : wmask0;
      mem_wdata = (state_q == BEAT1) ? wdata1 : wdata0;
    end
    resp_valid  = (state_q == RESP);
    resp_except = resp_valid && except_q;
    resp_rdata  = (resp_valid && !except_q && !we_q) ? ext_rdata : '0;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a 32-bit instance for most cases plus a 64-bit
// instance for doubleword access; misaligned cases follow LSU_MISALIGNED_EN.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, req_uext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_except;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        req_valid64, req_ready64, req_we64, req_uext64;
  logic [1:0]  req_size64;
  logic [63:0] req_addr64, req_wdata64;
  logic        resp_valid64, resp_except64;
  logic [63:0] resp_rdata64;
  logic        mem_valid64, mem_ready64, mem_we64;
  logic [63:0] mem_addr64, mem_wdata64, mem_rdata64;
  logic [7:0]  mem_wmask64;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_uext(req_uext), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_except(resp_except), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
    .req_size(req_size64), .req_uext(req_uext64), .req_addr(req_addr64),
    .req_wdata(req_wdata64), .resp_valid(resp_valid64), .resp_rdata(resp_rdata64),
    .resp_except(resp_except64), .mem_valid(mem_valid64), .mem_ready(mem_ready64),
    .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wmask(mem_wmask64),
    .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a request for one edge; returns just after the acceptance edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_uext  = uext;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    chk("req_ready_before_accept", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_uext = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 1'b1; mem_rdata = 0;
    req_valid64 = 0; req_we64 = 0; req_size64 = 0; req_uext64 = 0; req_addr64 = 0;
    req_wdata64 = 0; mem_ready64 = 1'b1; mem_rdata64 = 0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 4'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);

    // store word, aligned
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("sw_mem_valid", mem_valid, 1'b1);
    chk("sw_mem_we", mem_we, 1'b1);
    chk("sw_mem_addr", mem_addr, 32'h100);
    chk("sw_mem_wmask", mem_wmask, 4'b1111);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_resp_early", resp_valid, 1'b0);
    chk("sw_req_ready_busy", req_ready, 1'b0);
    tick();
    chk("sw_resp_valid", resp_valid, 1'b1);
    chk("sw_resp_except", resp_except, 1'b0);
    chk("sw_resp_rdata", resp_rdata, 32'h0);
    chk("sw_mem_valid_done", mem_valid, 1'b0);
    tick();
    chk("sw_resp_one_pulse", resp_valid, 1'b0);

    // load byte, sign- and zero-extended
    mem_rdata = 32'h80FFFFFF;
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    chk("lb_mem_addr", mem_addr, 32'h100);
    chk("lb_mem_we", mem_we, 1'b0);
    chk("lb_mem_wmask", mem_wmask, 4'h0);
    tick();
    chk("lb_resp_valid", resp_valid, 1'b1);
    chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
    tick();
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    tick();
    chk("lbu_rdata", resp_rdata, 32'h00000080);
    tick();

    // load half at 0x102 with sign bit set in upper lanes
    mem_rdata = 32'hC0DE1234;
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    tick();
    chk("lh_rdata", resp_rdata, 32'hFFFFC0DE);
    tick();

`ifdef LSU_MISALIGNED_EN
    mem_rdata = 32'h11223344;
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    chk("lwm_b0_addr", mem_addr, 32'h100);
    tick();
    chk("lwm_b1_valid", mem_valid, 1'b1);
    chk("lwm_b1_addr", mem_addr, 32'h104);
    chk("lwm_b1_resp", resp_valid, 1'b0);
    mem_rdata = 32'h55667788;
    tick();
    chk("lwm_resp_valid", resp_valid, 1'b1);
    chk("lwm_except", resp_except, 1'b0);
    chk("lwm_rdata", resp_rdata, 32'h77881122);
    tick();

    issue(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000ABCD);
    chk("shm_b0_addr", mem_addr, 32'h100);
    chk("shm_b0_wmask", mem_wmask, 4'b1000);
    chk("shm_b0_wdata", mem_wdata, 32'hCD000000);
    tick();
    chk("shm_b1_addr", mem_addr, 32'h104);
    chk("shm_b1_wmask", mem_wmask, 4'b0001);
    chk("shm_b1_wdata", mem_wdata, 32'h000000AB);
    tick();
    chk("shm_resp_valid", resp_valid, 1'b1);
    chk("shm_except", resp_except, 1'b0);
    tick();
`else
    mem_rdata = 32'h11223344;
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    chk("lwm_mem_valid", mem_valid, 1'b0);
    chk("lwm_resp_valid", resp_valid, 1'b1);
    chk("lwm_except", resp_except, 1'b1);
    chk("lwm_rdata", resp_rdata, 32'h0);
    tick();
    chk("lwm_mem_valid_after", mem_valid, 1'b0);

    issue(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000ABCD);
    chk("shm_mem_valid", mem_valid, 1'b0);
    chk("shm_except", resp_except, 1'b1);
    tick();
`endif

    // backpressure, then reset mid-beat
    mem_ready = 1'b0;
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_valid", mem_valid, 1'b1);
      chk("bp_mem_addr", mem_addr, 32'h200);
      chk("bp_mem_wmask", mem_wmask, 4'b1111);
      chk("bp_mem_wdata", mem_wdata, 32'h12345678);
      chk("bp_resp_valid", resp_valid, 1'b0);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("rstmid_req_ready", req_ready, 1'b0);
    tick();
    chk("rstmid_mem_valid", mem_valid, 1'b0);
    chk("rstmid_req_ready_held", req_ready, 1'b0);
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_resp", resp_valid, 1'b0);
      tick();
    end
    chk("rstmid_idle_ready", req_ready, 1'b1);

    // doubleword on a 32-bit unit is illegal
    issue(1'b0, 2'b11, 1'b0, 32'h108, 32'h0);
    chk("sz11_resp_valid", resp_valid, 1'b1);
    chk("sz11_except", resp_except, 1'b1);
    chk("sz11_rdata", resp_rdata, 32'h0);
    chk("sz11_mem_valid", mem_valid, 1'b0);
    tick();
    chk("sz11_one_pulse", resp_valid, 1'b0);

    // 64-bit instance: ld, lw with sign extension, sw into upper lanes
    mem_rdata64 = 64'h0123456789ABCDEF;
    req_valid64 = 1'b1; req_we64 = 1'b0; req_size64 = 2'b11; req_uext64 = 1'b0;
    req_addr64 = 64'h8;
    #1;
    chk("ld64_req_ready", req_ready64, 1'b1);
    tick();
    req_valid64 = 1'b0;
    chk("ld64_mem_valid", mem_valid64, 1'b1);
    chk("ld64_mem_addr", mem_addr64, 64'h8);
    tick();
    chk("ld64_resp_valid", resp_valid64, 1'b1);
    chk("ld64_except", resp_except64, 1'b0);
    chk("ld64_rdata", resp_rdata64, 64'h0123456789ABCDEF);
    tick();

    mem_rdata64 = 64'h80000000_00000000;
    req_valid64 = 1'b1; req_size64 = 2'b10; req_addr64 = 64'h1C;
    tick();
    req_valid64 = 1'b0;
    chk("lw64_mem_addr", mem_addr64, 64'h18);
    tick();
    chk("lw64_rdata", resp_rdata64, 64'hFFFFFFFF80000000);
    tick();

    req_valid64 = 1'b1; req_we64 = 1'b1; req_size64 = 2'b10; req_addr64 = 64'h24;
    req_wdata64 = 64'h00000000CAFEF00D;
    tick();
    req_valid64 = 1'b0;
    chk("sw64_mem_addr", mem_addr64, 64'h20);
    chk("sw64_mem_wmask", mem_wmask64, 8'hF0);
    chk("sw64_mem_wdata", mem_wdata64, 64'hCAFEF00D00000000);
    tick();
    chk("sw64_resp_rdata", resp_rdata64, 64'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
